mem_wb_reg: RTL

//  MEM->WB pipeline register and writeback stage; directly downstream of the EX/MEM register.

---
 rtl/mem_wb_reg_pkg.sv | 18 +
 rtl/mem_wb_reg_wb_sel.sv | 21 ++
 rtl/mem_wb_reg.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_wb_reg_pkg.sv
// MEM->WB payload layout and writeback-select encodings shared by the WB stage.
// Layout is {RegWrite, MemtoReg[3:0], rd[4:0], result[31:0], rdata[31:0]}, MSB first.
package mem_wb_reg_pkg;

    localparam int MEM_DATA_W = 74;

    localparam int RDATA_LSB  = 0;
    localparam int RESULT_LSB = 32;
    localparam int RD_LSB     = 64;
    localparam int M2R_LSB    = 69;
    localparam int RWR_BIT    = 73;

    localparam logic [3:0] WB_SEL_ALU  = 4'b0001;
    localparam logic [3:0] WB_SEL_LOAD = 4'b0010;
    localparam logic [3:0] WB_SEL_LINK = 4'b0100;
    localparam logic [3:0] WB_SEL_IMM  = 4'b1000;

endpackage

// File: rtl/mem_wb_reg_wb_sel.sv
// Writeback value select; purely combinational, zero latency, no flow control.
// Only the load encoding picks rdata; every other code (including malformed ones) falls back to result.
module mem_wb_reg_wb_sel
    import mem_wb_reg_pkg::*;
(
    input  logic [3:0]  sel,
    input  logic [31:0] result,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);

    always_comb begin
        wdata = result;
        case (sel)
            WB_SEL_LOAD: wdata = rdata;
            WB_SEL_ALU, WB_SEL_LINK, WB_SEL_IMM: wdata = result;
            default: wdata = result;
        endcase
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB register and writeback stage: one cycle from upstream valid to rf_we, 1 instr/cycle.
// wb_stall freezes a held instruction and back-pressures upstream via mem_wb_reg_allow_in.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32,
    parameter bit TRACE_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MEM_DATA_W-1:0]   mem_data,
    input  logic                    mem_to_wb_reg_valid,
    output logic                    mem_wb_reg_allow_in,
    input  logic                    wb_stall,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic                    wb_fwd_valid,
    output logic [4:0]              wb_fwd_rd,
    output logic [31:0]             wb_fwd_data,
    output logic                    retire_pulse,
    output logic [RETIRE_CNT_W-1:0] retire_cnt,
    output logic [4:0]              trace_rd,
    output logic [31:0]             trace_wdata
);

    logic                  valid;
    logic [MEM_DATA_W-1:0] payload;
    logic                  ready_go;
    logic                  reg_write;
    logic [3:0]            mem_to_reg;
    logic [4:0]            rd;
    logic [31:0]           result;
    logic [31:0]           rdata;
    logic [31:0]           wb_value;

    assign ready_go            = !wb_stall;
    assign mem_wb_reg_allow_in = !valid || ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (mem_wb_reg_allow_in) begin
            valid <= mem_to_wb_reg_valid;
            if (mem_to_wb_reg_valid) begin
                payload <= mem_data;
            end
        end
    end

    assign reg_write  = payload[RWR_BIT];
    assign mem_to_reg = payload[M2R_LSB +: 4];
    assign rd         = payload[RD_LSB +: 5];
    assign result     = payload[RESULT_LSB +: 32];
    assign rdata      = payload[RDATA_LSB +: 32];

    mem_wb_reg_wb_sel u_wb_sel (
        .sel    (mem_to_reg),
        .result (result),
        .rdata  (rdata),
        .wdata  (wb_value)
    );

    // Retirement ignores RegWrite; writes to x0 retire but never reach the register file.
    assign retire_pulse = valid && ready_go;
    assign rf_we        = retire_pulse && reg_write && (rd != 5'd0);
    assign rf_waddr     = rd;
    assign rf_wdata     = wb_value;
    assign wb_fwd_valid = rf_we;
    assign wb_fwd_rd    = rd;
    assign wb_fwd_data  = wb_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (retire_pulse) begin
            retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
        end
    end

    generate
        if (TRACE_EN) begin : g_trace
            always_ff @(posedge clk) begin
                if (reset) begin
                    trace_rd    <= '0;
                    trace_wdata <= '0;
                end else if (rf_we) begin
                    trace_rd    <= rd;
                    trace_wdata <= wb_value;
                end
            end
        end else begin : g_no_trace
            assign trace_rd    = '0;
            assign trace_wdata = '0;
        end
    endgenerate

endmodule
